// File: rtl/hex_disp_pkg.sv
// Shared types and default constants for the hex display register scheduler.
package hex_disp_pkg;

   // Fetch state machine: IDLE waits for a pending fetch, REQ holds the debug read open.
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam int NUM_REGS       = 32;
   localparam int SCROLL_CYCLES  = 50_000_000;
   localparam int REFRESH_CYCLES = 1_000_000;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int DATA_W         = 32;

endpackage

// File: rtl/mod_tick_counter.sv
// Modulo-MODULUS counter with enable and synchronous clear. 'tick' is high
// during the cycle the counter sits at its terminal count while enabled and
// not being cleared, so the edge that wraps the counter is the edge that
// consumes the tick.
module mod_tick_counter #(
   parameter int MODULUS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: tick is combinational so a clear in the same cycle can suppress it;
   // the owner registers whatever the tick causes.
   assign tick = en & ~clr & (cnt == LAST);

   // Count while enabled, wrap at the terminal count, clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hex_display_sched.sv
// Chooses which CPU register the hex display shows (keys or auto-scroll),
// fetches it over the register-file debug port and re-fetches it
// periodically. All outputs are registered.
module hex_display_sched #(
   parameter int NUM_REGS       = hex_disp_pkg::NUM_REGS,
   parameter int IDX_W          = $clog2(NUM_REGS),
   parameter int SCROLL_CYCLES  = hex_disp_pkg::SCROLL_CYCLES,
   parameter int REFRESH_CYCLES = hex_disp_pkg::REFRESH_CYCLES,
   parameter int TIMEOUT_CYCLES = hex_disp_pkg::TIMEOUT_CYCLES
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_key_next,
   input  logic             i_key_prev,
   input  logic             i_auto_en,
   output logic             o_dbg_req,
   output logic [IDX_W-1:0] o_dbg_addr,
   input  logic             i_dbg_ack,
   input  logic [31:0]      i_dbg_data,
   output logic [31:0]      o_disp_value,
   output logic [IDX_W-1:0] o_disp_idx,
   output logic             o_disp_valid,
   output logic             o_busy,
   output logic             o_err
);

   import hex_disp_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam int               TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic             pend;
   logic [TO_W-1:0]  to_cnt;
   logic             any_key;
   logic             scroll_tick;
   logic             refresh_tick;
   logic             step_next;
   logic             step_prev;
   logic             idx_change;
   logic [IDX_W-1:0] idx_nxt;

   assign any_key = i_key_next | i_key_prev;

   // Auto-scroll period: restarts on any key and whenever auto-scroll is off,
   // so a key in the terminal-count cycle swallows that tick.
   mod_tick_counter #(
      .MODULUS (SCROLL_CYCLES)
   ) u_scroll (
      .clk  (i_clk),
      .rst  (i_rst),
      .en   (i_auto_en),
      .clr  (any_key | ~i_auto_en),
      .tick (scroll_tick)
   );

   // Free-running refresh period for re-fetching the shown register.
   mod_tick_counter #(
      .MODULUS (REFRESH_CYCLES)
   ) u_refresh (
      .clk  (i_clk),
      .rst  (i_rst),
      .en   (1'b1),
      .clr  (1'b0),
      .tick (refresh_tick)
   );

   // Next selected index; both keys together cancel out.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latch is inferred.
      step_next = (i_key_next & ~i_key_prev) | scroll_tick;
      step_prev = i_key_prev & ~i_key_next;
      idx_nxt   = o_disp_idx;
      if (step_next) begin
         idx_nxt = (o_disp_idx == LAST_IDX) ? '0 : o_disp_idx + 1'b1;
      end else if (step_prev) begin
         idx_nxt = (o_disp_idx == '0) ? LAST_IDX : o_disp_idx - 1'b1;
      end
      idx_change = step_next | step_prev;
   end

   // Index, pending flag and fetch FSM with all of its registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         pend         <= 1'b1;
         to_cnt       <= '0;
         o_disp_idx   <= '0;
         o_disp_value <= '0;
         o_disp_valid <= 1'b0;
         o_dbg_req    <= 1'b0;
         o_dbg_addr   <= '0;
         o_busy       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_disp_idx <= idx_nxt;

         unique case (state)
            IDLE: begin
               if (pend) begin
                  state      <= REQ;
                  o_dbg_req  <= 1'b1;
                  o_dbg_addr <= o_disp_idx;
                  o_busy     <= 1'b1;
                  to_cnt     <= TO_LOAD;
                  pend       <= 1'b0;
               end
            end
            REQ: begin
               if (i_dbg_ack) begin
                  // Data for a register that is no longer selected is dropped;
                  // the index change has already queued a new fetch.
                  if (o_dbg_addr == o_disp_idx && !idx_change) begin
                     o_disp_value <= i_dbg_data;
                     o_disp_valid <= 1'b1;
                     o_err        <= 1'b0;
                  end
                  state     <= IDLE;
                  o_dbg_req <= 1'b0;
                  o_busy    <= 1'b0;
               end else if (to_cnt == '0) begin
                  state     <= IDLE;
                  o_dbg_req <= 1'b0;
                  o_busy    <= 1'b0;
                  o_err     <= 1'b1;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Later assignments win: a new request for a fetch survives the
         // clear above, and an index change invalidates the display even if
         // an ack lands in the same cycle.
         if (idx_change || refresh_tick) begin
            pend <= 1'b1;
         end
         if (idx_change) begin
            o_disp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hex_display_sched.sv
// Directed bench for hex_display_sched with a short scroll and refresh period.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_hex_display_sched;

   localparam int SCROLL  = 8;
   localparam int REFRESH = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_next;
   logic        key_prev;
   logic        auto_en;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic        dbg_ack;
   logic [31:0] dbg_data;
   logic [31:0] disp_value;
   logic [4:0]  disp_idx;
   logic        disp_valid;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   hex_display_sched #(
      .NUM_REGS       (32),
      .IDX_W          (5),
      .SCROLL_CYCLES  (SCROLL),
      .REFRESH_CYCLES (REFRESH),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_key_next   (key_next),
      .i_key_prev   (key_prev),
      .i_auto_en    (auto_en),
      .o_dbg_req    (dbg_req),
      .o_dbg_addr   (dbg_addr),
      .i_dbg_ack    (dbg_ack),
      .i_dbg_data   (dbg_data),
      .o_disp_value (disp_value),
      .o_disp_idx   (disp_idx),
      .o_disp_valid (disp_valid),
      .o_busy       (busy),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; key_next = 1'b0; key_prev = 1'b0; auto_en = 1'b0;
      dbg_ack = 1'b0; dbg_data = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic wait_req(input int budget, input string name);
      int n = 0;
      while (!dbg_req && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (dbg_req !== 1'b1) begin
         failures++;
         $display("FAIL %s: o_dbg_req still %b after %0d cycles", name, dbg_req, budget);
      end
   endtask

   task automatic ack_now(input logic [31:0] d);
      dbg_ack = 1'b1; dbg_data = d;
      step();
      dbg_ack = 1'b0; dbg_data = '0;
   endtask

   task automatic pulse(input logic n, input logic p);
      key_next = n; key_prev = p;
      step();
      key_next = 1'b0; key_prev = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; key_next = 1'b0; key_prev = 1'b0; auto_en = 1'b0;
      dbg_ack = 1'b0; dbg_data = '0;
      step();
      checks++; if ({dbg_req, disp_valid, busy, err} !== 4'b0000) begin failures++;
         $display("FAIL reset_flags: req/valid/busy/err=%b expected 0000", {dbg_req, disp_valid, busy, err}); end
      checks++; if ({disp_idx, dbg_addr} !== 10'd0) begin failures++;
         $display("FAIL reset_idx_addr: idx=%0d addr=%0d expected 0 0", disp_idx, dbg_addr); end
      checks++; if (disp_value !== 32'h0) begin failures++;
         $display("FAIL reset_value: got %h expected 00000000", disp_value); end
      step();
      rst = 1'b0;
      wait_req(4, "reset_first_req");
      checks++; if (dbg_addr !== 5'd0 || busy !== 1'b1) begin failures++;
         $display("FAIL reset_fetch_addr: addr=%0d busy=%b expected 0 1", dbg_addr, busy); end
      ack_now(32'hDEADBEEF);
      checks++; if (disp_value !== 32'hDEADBEEF || disp_valid !== 1'b1) begin failures++;
         $display("FAIL reset_fetch_value: value=%h valid=%b expected deadbeef 1", disp_value, disp_valid); end
      checks++; if (dbg_req !== 1'b0 || busy !== 1'b0) begin failures++;
         $display("FAIL reset_fetch_done: req=%b busy=%b expected 0 0", dbg_req, busy); end
   endtask

   task automatic test_keys();
      do_reset();
      wait_req(4, "keys_first_req");
      ack_now(32'h0000_0000);
      pulse(1'b0, 1'b1);
      checks++; if (disp_idx !== 5'd31 || disp_valid !== 1'b0) begin failures++;
         $display("FAIL prev_wrap: idx=%0d valid=%b expected 31 0", disp_idx, disp_valid); end
      wait_req(4, "prev_req");
      checks++; if (dbg_addr !== 5'd31) begin failures++;
         $display("FAIL prev_addr: got %0d expected 31", dbg_addr); end
      ack_now(32'h1F1F_1F1F);
      checks++; if (disp_value !== 32'h1F1F_1F1F || disp_valid !== 1'b1) begin failures++;
         $display("FAIL prev_value: value=%h valid=%b expected 1f1f1f1f 1", disp_value, disp_valid); end
      pulse(1'b1, 1'b0);
      checks++; if (disp_idx !== 5'd0 || disp_valid !== 1'b0 || dbg_req !== 1'b0) begin failures++;
         $display("FAIL next_wrap: idx=%0d valid=%b req=%b expected 0 0 0", disp_idx, disp_valid, dbg_req); end
      step();
      checks++; if (dbg_req !== 1'b1 || dbg_addr !== 5'd0 || disp_valid !== 1'b0) begin failures++;
         $display("FAIL next_req: req=%b addr=%0d valid=%b expected 1 0 0", dbg_req, dbg_addr, disp_valid); end
      ack_now(32'h0000_A0A0);
      checks++; if (disp_value !== 32'h0000_A0A0 || disp_valid !== 1'b1) begin failures++;
         $display("FAIL next_value: value=%h valid=%b expected 0000a0a0 1", disp_value, disp_valid); end
      pulse(1'b1, 1'b1);
      checks++; if (disp_idx !== 5'd0 || disp_valid !== 1'b1) begin failures++;
         $display("FAIL both_keys: idx=%0d valid=%b expected 0 1", disp_idx, disp_valid); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (dbg_req !== 1'b0) begin failures++;
            $display("FAIL both_keys_no_req: req=%b at cycle %0d expected 0", dbg_req, i); end
         step();
      end
   endtask

   task automatic test_timeout();
      do_reset();
      wait_req(4, "to_first_req");
      ack_now(32'h1234_5678);
      wait_req(REFRESH + 20, "to_refresh_req");
      checks++; if (dbg_addr !== 5'd0) begin failures++;
         $display("FAIL to_refresh_addr: got %0d expected 0", dbg_addr); end
      for (int i = 0; i < 15; i++) step();
      checks++; if (dbg_req !== 1'b1 || err !== 1'b0) begin failures++;
         $display("FAIL to_early: req=%b err=%b after 15 cycles expected 1 0", dbg_req, err); end
      step();
      checks++; if (dbg_req !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin failures++;
         $display("FAIL to_expire: req=%b err=%b busy=%b expected 0 1 0", dbg_req, err, busy); end
      checks++; if (disp_value !== 32'h1234_5678 || disp_valid !== 1'b1) begin failures++;
         $display("FAIL to_value_kept: value=%h valid=%b expected 12345678 1", disp_value, disp_valid); end
      wait_req(REFRESH + 20, "to_second_refresh");
      ack_now(32'hCAFE_0000);
      checks++; if (err !== 1'b0 || disp_value !== 32'hCAFE_0000) begin failures++;
         $display("FAIL to_recover: err=%b value=%h expected 0 cafe0000", err, disp_value); end
   endtask

   task automatic test_discard();
      do_reset();
      wait_req(4, "disc_req0");
      ack_now(32'h0000_00D0);
      pulse(1'b1, 1'b0); wait_req(4, "disc_req1"); ack_now(32'h0000_00D1);
      pulse(1'b1, 1'b0); wait_req(4, "disc_req2"); ack_now(32'h0000_00D2);
      pulse(1'b1, 1'b0); wait_req(4, "disc_req3");
      checks++; if (dbg_addr !== 5'd3) begin failures++;
         $display("FAIL disc_addr3: got %0d expected 3", dbg_addr); end
      pulse(1'b1, 1'b0);
      checks++; if (disp_idx !== 5'd4 || dbg_addr !== 5'd3 || dbg_req !== 1'b1) begin failures++;
         $display("FAIL disc_addr_hold: idx=%0d addr=%0d req=%b expected 4 3 1", disp_idx, dbg_addr, dbg_req); end
      ack_now(32'h0000_1111);
      checks++; if (disp_value !== 32'h0000_00D2 || disp_valid !== 1'b0 || dbg_req !== 1'b0) begin failures++;
         $display("FAIL disc_dropped: value=%h valid=%b req=%b expected 000000d2 0 0", disp_value, disp_valid, dbg_req); end
      step();
      checks++; if (dbg_req !== 1'b1 || dbg_addr !== 5'd4) begin failures++;
         $display("FAIL disc_refetch: req=%b addr=%0d expected 1 4", dbg_req, dbg_addr); end
      ack_now(32'h0000_2222);
      checks++; if (disp_value !== 32'h0000_2222 || disp_valid !== 1'b1) begin failures++;
         $display("FAIL disc_value: value=%h valid=%b expected 00002222 1", disp_value, disp_valid); end
   endtask

   task automatic test_scroll();
      do_reset();
      auto_en = 1'b1;
      for (int i = 0; i < SCROLL - 1; i++) step();
      checks++; if (disp_idx !== 5'd0) begin failures++;
         $display("FAIL scroll_early: idx=%0d expected 0", disp_idx); end
      step();
      checks++; if (disp_idx !== 5'd1) begin failures++;
         $display("FAIL scroll_first: idx=%0d expected 1", disp_idx); end
      for (int i = 0; i < SCROLL; i++) step();
      checks++; if (disp_idx !== 5'd2) begin failures++;
         $display("FAIL scroll_second: idx=%0d expected 2", disp_idx); end
      for (int i = 0; i < SCROLL - 1; i++) step();
      pulse(1'b1, 1'b0);
      checks++; if (disp_idx !== 5'd3) begin failures++;
         $display("FAIL scroll_key_wins: idx=%0d expected 3", disp_idx); end
      for (int i = 0; i < SCROLL - 1; i++) step();
      checks++; if (disp_idx !== 5'd3) begin failures++;
         $display("FAIL scroll_restart_early: idx=%0d expected 3", disp_idx); end
      step();
      checks++; if (disp_idx !== 5'd4) begin failures++;
         $display("FAIL scroll_restart: idx=%0d expected 4", disp_idx); end
      auto_en = 1'b0;
      for (int i = 0; i < 2 * SCROLL; i++) step();
      checks++; if (disp_idx !== 5'd4) begin failures++;
         $display("FAIL scroll_off: idx=%0d expected 4", disp_idx); end
   endtask

   task automatic test_async_reset();
      do_reset();
      wait_req(4, "ar_first_req");
      ack_now(32'h55AA_55AA);
      wait_req(REFRESH + 20, "ar_refresh_req");
      for (int i = 0; i < 16; i++) step();
      wait_req(REFRESH + 20, "ar_second_req");
      checks++; if ({dbg_req, disp_valid, err} !== 3'b111) begin failures++;
         $display("FAIL ar_precond: req/valid/err=%b expected 111", {dbg_req, disp_valid, err}); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if ({dbg_req, disp_valid, err, busy} !== 4'b0000) begin failures++;
         $display("FAIL ar_immediate: req/valid/err/busy=%b expected 0000", {dbg_req, disp_valid, err, busy}); end
      checks++; if (disp_value !== 32'h0) begin failures++;
         $display("FAIL ar_value: got %h expected 00000000", disp_value); end
      step();
      rst = 1'b0;
      wait_req(4, "ar_refetch");
      checks++; if (dbg_addr !== 5'd0) begin failures++;
         $display("FAIL ar_refetch_addr: got %0d expected 0", dbg_addr); end
   endtask

   initial begin
      test_reset();
      test_keys();
      test_timeout();
      test_discard();
      test_scroll();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex_display_sched.md
Name: hex_display_sched

Overview:
- Selects which CPU register is shown on the 8-digit hex display and fetches its value over the register-file debug read port.
- Drives the 32-bit value and index consumed by the seven-segment decoder.
- Register selection is by next/prev keys or by auto-scroll.
- The shown register is re-fetched periodically so the display tracks live contents.

Parameters:
- NUM_REGS, 32, number of selectable registers (index wraps modulo NUM_REGS)
- IDX_W, 5, index width, $clog2(NUM_REGS)
- SCROLL_CYCLES, 50_000_000, auto-scroll period in clocks
- REFRESH_CYCLES, 1_000_000, re-fetch period in clocks
- TIMEOUT_CYCLES, 16, clocks allowed between request and ack

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_key_next  in  1  single-cycle pulse (already debounced): index +1
- i_key_prev  in  1  single-cycle pulse (already debounced): index -1
- i_auto_en  in  1  level: auto-scroll enable
- o_dbg_req  out  1  debug read request
- o_dbg_addr  out  IDX_W  debug read address, stable while o_dbg_req=1
- i_dbg_ack  in  1  single-cycle acknowledge; i_dbg_data valid in the same cycle
- i_dbg_data  in  32  read data
- o_disp_value  out  32  value to the decoder
- o_disp_idx  out  IDX_W  currently selected register
- o_disp_valid  out  1  o_disp_value belongs to o_disp_idx
- o_busy  out  1  FSM in REQ
- o_err  out  1  sticky until the next successful fetch: last fetch timed out

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - o_disp_idx=0, o_disp_value=0, o_disp_valid=0, o_dbg_req=0, o_dbg_addr=0, o_busy=0, o_err=0.
  - Both timers cleared; FSM=IDLE; pend=1, so register 0 is fetched right after reset release.
- All outputs are registered.
- Index update, in the cycle after the sampling edge:
  - next only: idx+1, with NUM_REGS-1 wrapping to 0.
  - prev only: idx-1, with 0 wrapping to NUM_REGS-1.
  - next and prev together: no change, no fetch.
  - On any change: o_disp_valid<=0 and pend<=1.
- Auto-scroll:
  - Scroll counter counts only while i_auto_en=1.
  - It clears when i_auto_en=0 or on any key pulse.
  - On reaching SCROLL_CYCLES-1 it wraps to 0 and acts as next.
  - A key pulse in the same cycle as the terminal count wins; the tick is discarded.
- Refresh: free-running counter, modulo REFRESH_CYCLES; terminal count sets pend, with no change to valid.
- FSM IDLE:
  - If pend: go to REQ, o_dbg_req<=1, o_dbg_addr<=o_disp_idx, clear pend, load the timeout counter.
  - A pend set in the same cycle is kept for the next pass.
- FSM REQ:
  - i_dbg_ack=1:
    - If o_dbg_addr==o_disp_idx: o_disp_value<=i_dbg_data, o_disp_valid<=1, o_err<=0.
    - Otherwise the data is discarded; the pending refetch is already set by the index change.
    - Then o_dbg_req<=0 and go to IDLE.
  - No ack for TIMEOUT_CYCLES clocks: o_err<=1, o_dbg_req<=0, go to IDLE; o_disp_value and o_disp_valid are unchanged.
  - Index changes during REQ do not alter o_dbg_addr.
- i_dbg_ack outside REQ is ignored.
- Latency: key pulse at cycle t gives the new idx at t+1 and o_dbg_req at t+2. An ack at t+2 gives value and valid at t+3.
- Minimum fetch-to-fetch spacing is 2 clocks, because one IDLE cycle is always taken.

Decomposition:
- Package hex_disp_pkg holds:
  - the state enum {IDLE, REQ};
  - the default constants NUM_REGS, SCROLL_CYCLES, REFRESH_CYCLES, TIMEOUT_CYCLES.
- Sub-module mod_tick_counter: parameterized modulo counter with enable, synchronous clear and a terminal-count pulse. It is instantiated twice, once for scroll and once for refresh.
- The timeout counter is inline.

Test Plan:
- Reset release, with ack one cycle after req and data 0xDEADBEEF:
  - o_dbg_addr=0.
  - o_disp_value=0xDEADBEEF and o_disp_valid=1 two cycles after req.
- Idx=31, pulse next:
  - Idx becomes 0 and valid drops for at least 2 cycles.
  - A fetch of addr 0 is issued.
  - Idx=0 with prev gives 31.
  - next and prev together give no change and no req.
- Ack withheld for 16 cycles:
  - o_err=1, req drops, value unchanged.
  - The next refresh fetch is acked and clears o_err.
- During REQ for addr 3, pulse next, then ack with 0x1111:
  - Data is discarded and value is not updated.
  - A new req for addr 4 follows, and its ack with 0x2222 gives value=0x2222, valid=1.
- SCROLL_CYCLES=8, i_auto_en=1:
  - Idx increments every 8 cycles.
  - A next pulse on the terminal-count cycle increments only once and restarts the 8-cycle period.
- Assert i_rst while o_dbg_req=1: req, valid and err go to 0 in the same cycle without waiting for a clock edge.
